// File: rtl/ntt_dout_collector.sv
// Output-side collector for the NTT core: captures the result burst, applies the final
// conditional subtraction of q, de-interleaves into natural order and serves it valid/ready.
module ntt_dout_collector #(
    parameter int DATA_W    = 32,
    parameter int MAX_DEPTH = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           ring_depth,
    input  logic [DATA_W-1:0]    q,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic [MAX_DEPTH-1:0] out_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic                 range_err,
    output logic                 ovf_err
);
    localparam int DEPTH = 1 << MAX_DEPTH;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     q_q;
    logic [MAX_DEPTH-1:0]  nm1_q, half_q;
    logic [MAX_DEPTH-1:0]  m_q;
    logic                  cap_full_q;
    logic                  wr_en_q, wr_last_q;
    logic [MAX_DEPTH-1:0]  wr_addr_q;
    logic [DATA_W-1:0]     wr_data_q;
    logic                  cfg_err_q, done_q, range_err_q, ovf_err_q;
    logic [MAX_DEPTH-1:0]  ptr_q, s1_idx_q, out_idx_q;
    logic                  rd_done_q, s1_v_q, out_valid_q;
    logic [DATA_W-1:0]     mem_rd_q, out_data_q;
    logic [DATA_W-1:0]     mem [DEPTH];

    logic                  cfg_ok, in_capture, in_drain, cap_acc;
    logic                  out_fire, s2_load, s1_adv, rd_en, last_xfer, range_hit;
    logic [MAX_DEPTH:0]    n_full;
    logic [DATA_W:0]       two_q;
    logic [DATA_W-1:0]     red;
    logic [MAX_DEPTH-1:0]  wr_addr_d;

    assign cfg_ok    = (ring_depth != 4'd0) && (int'(ring_depth) <= MAX_DEPTH);
    assign n_full    = {{MAX_DEPTH{1'b0}}, 1'b1} << ring_depth;
    // 2q is formed one bit wider than the data so the range test never wraps.
    assign two_q     = {q_q, 1'b0};
    assign range_hit = {1'b0, in_data} >= two_q;
    assign red       = (in_data >= q_q) ? in_data - q_q : in_data;
    assign wr_addr_d = m_q[0] ? (m_q >> 1) + half_q : (m_q >> 1);

    // Readout: synchronous buffer read (stage 1) feeding the output register (stage 2).
    assign out_fire  = out_valid_q && out_ready;
    assign s2_load   = !out_valid_q || out_fire;
    assign s1_adv    = s1_v_q && s2_load;
    assign rd_en     = in_drain && !rd_done_q && (!s1_v_q || s1_adv);
    assign last_xfer = out_fire && (out_idx_q == nm1_q);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every variable assigned in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = cfg_ok ? S_CAPTURE : S_IDLE;
        end else begin
            case (state_q)
                S_CAPTURE: if (wr_en_q && wr_last_q) state_d = S_DRAIN;
                S_DRAIN:   if (last_xfer)            state_d = S_IDLE;
                default:   ;
            endcase
        end
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        in_capture = (state_q == S_CAPTURE) && !start;
        in_drain   = (state_q == S_DRAIN) && (state_d == S_DRAIN);
        cap_acc    = in_capture && in_valid && !cap_full_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q         <= '0;
            nm1_q       <= '0;
            half_q      <= '0;
            m_q         <= '0;
            cap_full_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_last_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cfg_err_q   <= 1'b0;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= start && !cfg_ok;
            done_q    <= last_xfer && !start;
            wr_en_q   <= cap_acc;
            wr_last_q <= cap_acc && (m_q == nm1_q);
            wr_addr_q <= wr_addr_d;
            wr_data_q <= red;
            if (start && cfg_ok) begin
                q_q         <= q;
                nm1_q       <= MAX_DEPTH'(n_full - (MAX_DEPTH+1)'(1));
                half_q      <= MAX_DEPTH'(n_full >> 1);
                m_q         <= '0;
                cap_full_q  <= 1'b0;
                range_err_q <= 1'b0;
                ovf_err_q   <= 1'b0;
            end else begin
                if (cap_acc) begin
                    m_q <= m_q + MAX_DEPTH'(1);
                    if (m_q == nm1_q) cap_full_q  <= 1'b1;
                    if (range_hit)    range_err_q <= 1'b1;
                end
                // Any word the capture path does not take is an overflow.
                if (in_valid && !start && !cap_acc) ovf_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !in_drain) begin
            ptr_q       <= '0;
            rd_done_q   <= 1'b0;
            s1_v_q      <= 1'b0;
            out_valid_q <= 1'b0;
            if (reset) begin
                s1_idx_q   <= '0;
                out_idx_q  <= '0;
                out_data_q <= '0;
            end
        end else begin
            if (rd_en) begin
                ptr_q    <= ptr_q + MAX_DEPTH'(1);
                s1_idx_q <= ptr_q;
                if (ptr_q == nm1_q) rd_done_q <= 1'b1;
            end
            if (rd_en)       s1_v_q <= 1'b1;
            else if (s1_adv) s1_v_q <= 1'b0;
            if (s2_load) out_valid_q <= s1_v_q;
            if (s1_adv) begin
                out_idx_q  <= s1_idx_q;
                out_data_q <= mem_rd_q;
            end
        end
    end

    // NOTE: the buffer is not reset; each location is written by a capture before it is read.
    always_ff @(posedge clk) begin
        if (wr_en_q) mem[wr_addr_q] <= wr_data_q;
        if (rd_en)   mem_rd_q       <= mem[ptr_q];
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign range_err = range_err_q;
    assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_ntt_dout_collector.sv
// Self-checking bench for ntt_dout_collector: config table, reduction table, and
// scoreboard-checked bursts covering reorder, backpressure, abort, overflow and reset.
module tb_ntt_dout_collector;
    localparam int DATA_W    = 32;
    localparam int MAX_DEPTH = 12;

    logic                 clk = 1'b0;
    logic                 reset, start, in_valid, out_ready;
    logic [3:0]           ring_depth;
    logic [DATA_W-1:0]    q, in_data, out_data;
    logic                 out_valid, busy, done, cfg_err, range_err, ovf_err;
    logic [MAX_DEPTH-1:0] out_idx;

    typedef struct { int idx; logic [31:0] data; } exp_t;
    typedef struct { logic [3:0] depth; logic exp_cfg_err; logic exp_busy; } cfg_vec_t;
    typedef struct { logic [31:0] x; logic [31:0] exp_out; logic exp_range; } red_vec_t;

    exp_t        sb[$];
    logic [31:0] stream [4096];
    cfg_vec_t    cfg_tab [7];
    red_vec_t    red_tab [4];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          gaps = 1'b0;

    ntt_dout_collector #(.DATA_W(DATA_W), .MAX_DEPTH(MAX_DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .ring_depth(ring_depth), .q(q),
        .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done), .cfg_err(cfg_err), .range_err(range_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_red(input logic [31:0] x, input logic [31:0] qq);
        return (x >= qq) ? x - qq : x;
    endfunction

    function automatic logic exp_range(input int n, input logic [31:0] qq);
        logic r = 1'b0;
        for (int m = 0; m < n; m++)
            if (longint'(stream[m]) >= 2 * longint'(qq)) r = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_range_err", range_err, 0);
        check("rst_ovf_err", ovf_err, 0);
    endtask

    task automatic do_start(input logic [3:0] d, input logic [31:0] qq);
        start = 1'b1; ring_depth = d; q = qq;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_random(input int n, input logic [31:0] qq);
        for (int m = 0; m < n; m++) stream[m] = $urandom_range(0, 2 * qq - 1);
    endtask

    task automatic send(input int n);
        for (int m = 0; m < n; m++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1; in_data = stream[m];
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Natural index i holds stream word 2i (lower half) or 2(i-n/2)+1 (upper half).
    task automatic push_expected(input int n, input logic [31:0] qq);
        exp_t e;
        int   m;
        for (int i = 0; i < n; i++) begin
            m = (i < n / 2) ? 2 * i : 2 * (i - n / 2) + 1;
            e.idx = i; e.data = ref_red(stream[m], qq);
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int n, input bit rnd, input bit expect_done);
        int          got = 0;
        int          cyc = 0;
        int          first_cyc = -1;
        int          last_cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] hd = '0;
        logic [11:0] hi = '0;
        exp_t        e;
        while (got < n && cyc < n * 8 + 50) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, hd);
                check("stall_idx", out_idx, hi);
            end
            stalled = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    check("sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("out_idx", out_idx, e.idx);
                        check("out_data", out_data, e.data);
                    end
                    got++;
                end else begin
                    stalled = 1'b1; hd = out_data; hi = out_idx;
                end
            end
            tick();
            cyc++;
        end
        check("transfer_count", got, n);
        if (!rnd) check("no_bubble", last_cyc - first_cyc, n - 1);
        if (expect_done) begin
            check("done_pulse", done, 1);
            check("busy_after_done", busy, 0);
            tick();
            check("done_once", done, 0);
        end
        out_ready = 1'b0;
    endtask

    task automatic run_job(input int depth, input logic [31:0] qq, input bit rnd);
        int n;
        n = 1 << depth;
        do_start(4'(depth), qq);
        check("busy_capture", busy, 1);
        send(n);
        push_expected(n, qq);
        drain(n, rnd, 1'b1);
        check("range_err_job", range_err, exp_range(n, qq));
        check("ovf_err_job", ovf_err, 0);
    endtask

    initial begin
        logic [31:0] hold_d;
        logic [11:0] hold_i;

        cfg_tab[0] = '{4'd0,  1'b1, 1'b0};
        cfg_tab[1] = '{4'd3,  1'b0, 1'b1};
        cfg_tab[2] = '{4'd13, 1'b1, 1'b0};
        cfg_tab[3] = '{4'd12, 1'b0, 1'b1};
        cfg_tab[4] = '{4'd15, 1'b1, 1'b0};
        cfg_tab[5] = '{4'd1,  1'b0, 1'b1};
        cfg_tab[6] = '{4'd0,  1'b1, 1'b0};
        red_tab[0] = '{32'd12289, 32'd0,     1'b0};
        red_tab[1] = '{32'd12288, 32'd12288, 1'b0};
        red_tab[2] = '{32'd24577, 32'd12288, 1'b0};
        red_tab[3] = '{32'd24578, 32'd12289, 1'b1};

        reset = 1'b1; start = 1'b0; ring_depth = '0; q = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_values();

        // Configuration legality, including aborts into CAPTURE and back to IDLE.
        for (int i = 0; i < 7; i++) begin
            do_start(cfg_tab[i].depth, 32'd12289);
            check("cfg_err", cfg_err, cfg_tab[i].exp_cfg_err);
            check("cfg_busy", busy, cfg_tab[i].exp_busy);
        end
        tick();
        check("cfg_err_one_cycle", cfg_err, 0);

        // Reorder of a small ring.
        for (int m = 0; m < 8; m++) stream[m] = 100 + m;
        run_job(3, 32'd12289, 1'b0);

        // Reduction table: range_err sampled after each captured word.
        do_start(4'd2, 32'd12289);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = red_tab[i].x;
            tick();
            check("range_after_word", range_err, red_tab[i].exp_range);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back('{i, red_tab[i].exp_out});
        drain(4, 1'b0, 1'b1);

        // Largest modulus: 2q must not wrap.
        stream[0] = 32'hFFFF_FFFF; stream[1] = 32'hFFFF_FFFE;
        run_job(1, 32'hFFFF_FFFF, 1'b0);

        // Overflow during DRAIN leaves the presented word untouched.
        do_start(4'd3, 32'd7681);
        fill_random(8, 32'd7681);
        send(8);
        push_expected(8, 32'd7681);
        for (int c = 0; c < 10 && !out_valid; c++) tick();
        check("drain_first_valid", out_valid, 1);
        hold_d = out_data; hold_i = out_idx;
        in_valid = 1'b1; in_data = 32'hDEAD;
        tick();
        in_valid = 1'b0;
        check("ovf_err_drain", ovf_err, 1);
        check("ovf_hold_valid", out_valid, 1);
        check("ovf_hold_data", out_data, hold_d);
        check("ovf_hold_idx", out_idx, hold_i);
        drain(8, 1'b0, 1'b1);
        check("ovf_sticky", ovf_err, 1);

        // Abort after 5 words; the word alongside the restart start is ignored.
        do_start(4'd4, 32'd97);
        fill_random(5, 32'd97);
        send(5);
        start = 1'b1; ring_depth = 4'd4; q = 32'd97; in_valid = 1'b1; in_data = 32'd5;
        tick();
        start = 1'b0; in_valid = 1'b0;
        check("abort_ovf_clear", ovf_err, 0);
        check("abort_busy", busy, 1);
        fill_random(16, 32'd97);
        send(16);
        push_expected(16, 32'd97);
        drain(16, 1'b0, 1'b1);
        check("abort_ovf_after", ovf_err, 0);

        // Backpressure with input gaps.
        gaps = 1'b1;
        fill_random(1024, 32'd12289);
        run_job(10, 32'd12289, 1'b1);
        gaps = 1'b0;

        // Largest ring.
        fill_random(4096, 32'd3329);
        run_job(12, 32'd3329, 1'b0);

        // Reset in the middle of DRAIN, then a fresh job.
        fill_random(1024, 32'd12289);
        stream[5] = 32'd40000;
        do_start(4'd10, 32'd12289);
        send(1024);
        check("range_err_set", range_err, 1);
        push_expected(1024, 32'd12289);
        drain(300, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values();
        sb.delete();
        fill_random(8, 32'd12289);
        run_job(3, 32'd12289, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ntt_dout_collector.md
# ntt_dout_collector

Output-side collector for the parametrised NTT core. It captures the core's result burst, applies the final conditional subtraction of q, and de-interleaves the stream into natural coefficient order in an internal buffer. It then serves the ring to the host through a valid/ready readout port. It sits between the NTT core's `dout0` stream and the host interface. It replaces per-bench software reordering and generalises ring size (up to 2^MAX_DEPTH), data width and modulus at run time.

## Interface
- `DATA_W`, 32, coefficient/word width.
- `MAX_DEPTH`, 12, log2 of the largest supported ring; buffer holds 2^MAX_DEPTH words.
- `clk`  in  1  single clock, all logic rising-edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset (fixed).
- `start`  in  1  one-cycle pulse; latches `ring_depth`, `q`, begins capture.
- `ring_depth`  in  4  log2(n), sampled only on accepted `start`.
- `q`  in  DATA_W  modulus, sampled only on accepted `start`.
- `in_valid`  in  1  core output word valid.
- `in_data`  in  DATA_W  core output word, value in [0, 2q).
- `out_ready`  in  1  host accepts readout word.
- `out_valid`  out  1  readout word valid.
- `out_data`  out  DATA_W  reduced coefficient.
- `out_idx`  out  MAX_DEPTH  natural-order index of `out_data`.
- `busy`  out  1  high in CAPTURE or DRAIN.
- `done`  out  1  one-cycle pulse after last readout transfer.
- `cfg_err`  out  1  one-cycle pulse when `start` carries an illegal `ring_depth`.
- `range_err`  out  1  sticky: a captured word was ≥ 2q.
- `ovf_err`  out  1  sticky: `in_valid` seen outside CAPTURE.

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - `start` with 1 ≤ `ring_depth` ≤ MAX_DEPTH: latch n = 1<<ring_depth and q, clear m, `range_err`, `ovf_err`, go to CAPTURE.
  - Otherwise: pulse `cfg_err`, stay IDLE.
- CAPTURE, per accepted word (m = 0..n-1):
  - r = (x ≥ q) ? x−q : x.
  - If x ≥ 2q, set `range_err` and still store x−q.
  - Write address = m[0]==0 ? m>>1 : (m>>1) + n/2. Even words land in the lower half, odd words in the upper half.
  - After word n−1 is written, go to DRAIN.
- DRAIN:
  - Present indices 0..n−1 in order; a transfer is `out_valid && out_ready`.
  - `out_data`/`out_idx` hold stable while `out_valid && !out_ready`.
  - After index n−1 transfers, pulse `done` and return to IDLE.
- `start` in CAPTURE or DRAIN aborts the current job and re-enters CAPTURE with new config. Legality is checked as in IDLE; an illegal config pulses `cfg_err` and goes to IDLE. Buffer contents are not cleared and are overwritten.
- `in_valid` in IDLE or DRAIN: word dropped, `ovf_err` set.
- Comparison is full DATA_W unsigned; 2q is computed at DATA_W+1 bits, so no wrap.

## Timing
- Reset values:
  - State IDLE, m = 0.
  - `out_valid`, `out_data`, `out_idx`, `busy`, `done`, `cfg_err`, `range_err`, `ovf_err` all 0.
  - Buffer contents undefined.
- Capture:
  - A word accepted at cycle t is reduced and written at the edge ending t+1 (one register stage).
  - A word with `in_valid` in the same cycle as `start` is ignored (not counted, not an overflow).
- CAPTURE→DRAIN: state changes the cycle after the n-th word's write.
  - `out_valid` first rises no later than 2 cycles after entering DRAIN.
- Readout throughput is 1 word/cycle while `out_ready` is held high. Use a synchronous-read buffer with a prefetch register; no bubbles are allowed after the first word.
- `done` is asserted the cycle after the final transfer; `busy` falls in the same cycle.
- `reset` mid-operation: next cycle matches reset values; a pending readout is discarded.
- `cfg_err` is asserted the cycle after the offending `start`.

## Test plan
- Reorder: ring_depth=3, q=12289, stream 100..107, `out_ready`=1 → out idx 0..7 = 100,102,104,106,101,103,105,107; `done` pulses once.
- Reduction: ring_depth=2, q=12289, stream 12289, 12288, 24577, 24578 → out 0, 24577−12289=12288 (idx1), 12288 (idx2), 12289 (idx3); `range_err`=1 from the 4th word.
- Backpressure: ring_depth=10, random `out_ready` → exactly 1024 transfers, idx 0..1023 in order, data stable during stalls, matches reference de-interleave.
- Abort/restart: ring_depth=4, `start` after 5 words, then 16 fresh words → only the fresh 16 appear reordered.
- Errors: `start` with ring_depth=0 → `cfg_err` 1 cycle, `busy`=0. `in_valid` during DRAIN → `ovf_err`=1 and output unchanged.
- Reset mid-DRAIN (after 300 of 1024) → `out_valid`=0, `busy`=0, all flags 0 next cycle; a new job then completes correctly.
